// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file writeback arbiter: write-source select and writeback request.
package regfile_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int WB_DATA_W  = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [2:0] {
        WSEL_NONE = 3'b000,
        WSEL_ALU  = 3'b001,
        WSEL_JAL  = 3'b010,
        WSEL_EXT  = 3'b100
    } wsel_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
        reg_mask    = '0;
        reg_mask[r] = 1'b1;
    endfunction
endpackage

// File: rtl/ext_wb_fifo.sv
// Small FIFO buffering load responses; head visible combinationally, entry lands one cycle after push.
// Backpressure: in_rdy comes from the registered occupancy, so a pop frees a slot only on the next cycle.
module ext_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         head_vld,
    output logic [W-1:0] head_dat,
    input  logic         pop
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, do_pop;

    assign in_rdy   = (count_q != (PTR_W+1)'(DEPTH));
    assign head_vld = (count_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign push     = in_vld & in_rdy;
    assign do_pop   = pop & head_vld;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_dat;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the reg_file write port: JAL > ALU > buffered/bypassed load data, registered (1 cycle), plus load scoreboard.
// Backpressure: ext_ready drops when the response FIFO is full; issue_stall on load hazards or a starved FIFO head.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int n          = WB_DATA_W,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_is_load,
    output logic                  issue_stall,
    input  logic                  alu_we,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [n-1:0]          alu_data,
    input  logic                  jal_we,
    input  logic [REG_ADDR_W-1:0] jal_rd,
    input  logic [n-1:0]          pc_plus_four,
    input  logic                  ext_valid,
    input  logic [REG_ADDR_W-1:0] ext_rd,
    input  logic [n-1:0]          external_input,
    output logic                  ext_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [n-1:0]          rf_wdata,
    output logic [2:0]            rf_src,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  wb_conflict
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    wb_req_t               ext_req, head_dat, win_req;
    wsel_t                 win_sel;
    logic                  fifo_rdy, head_vld, fifo_push, fifo_pop, bypass;
    logic                  wr_en, ld_set, starve_stall;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [n-1:0]          rf_wdata_q, rf_wdata_d;
    wsel_t                 rf_src_q, rf_src_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  wb_conflict_q, wb_conflict_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;

    assign ext_req.rd   = ext_rd;
    assign ext_req.data = external_input;
    assign ext_ready    = n_reset & fifo_rdy;
    assign fifo_push    = ext_valid & ext_ready & ~bypass;

    ext_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(wb_req_t))
    ) u_fifo (
        .clk      (clk),
        .n_reset  (n_reset),
        .in_vld   (fifo_push),
        .in_dat   (ext_req),
        .in_rdy   (fifo_rdy),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .pop      (fifo_pop)
    );

    assign starve_stall = (starve_cnt_q == CNT_W'(STARVE_MAX));
    assign issue_stall  = (issue_valid & (pending_q[issue_rs1] | pending_q[issue_rs2] |
                                          pending_q[issue_rd])) | starve_stall;

    always_comb begin
        win_sel  = WSEL_NONE;
        win_req  = '0;
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        if (jal_we) begin
            win_sel      = WSEL_JAL;
            win_req.rd   = jal_rd;
            win_req.data = pc_plus_four;
        end else if (alu_we) begin
            win_sel      = WSEL_ALU;
            win_req.rd   = alu_rd;
            win_req.data = alu_data;
        end else if (head_vld) begin
            win_sel  = WSEL_EXT;
            win_req  = head_dat;
            fifo_pop = 1'b1;
        end else if (ext_valid && ext_ready) begin
            // Empty FIFO and idle port: skip the buffer entirely.
            win_sel = WSEL_EXT;
            win_req = ext_req;
            bypass  = 1'b1;
        end
    end

    always_comb begin
        wr_en         = (win_sel != WSEL_NONE) && (win_req.rd != '0);
        rf_we_d       = wr_en;
        rf_src_d      = wr_en ? win_sel : WSEL_NONE;
        rf_waddr_d    = wr_en ? win_req.rd : rf_waddr_q;
        rf_wdata_d    = wr_en ? win_req.data : rf_wdata_q;
        wb_conflict_d = wb_conflict_q | (alu_we & jal_we);

        // Clear before set so a same-cycle reissue of the same rd stays pending.
        ld_set    = issue_valid & issue_is_load & ~issue_stall & (issue_rd != '0);
        pending_d = pending_q;
        if (win_sel == WSEL_EXT) pending_d = pending_d & ~reg_mask(win_req.rd);
        if (ld_set)              pending_d = pending_d | reg_mask(issue_rd);

        if (!head_vld || fifo_pop)
            starve_cnt_d = '0;
        else if (!starve_stall)
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        else
            starve_cnt_d = starve_cnt_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            rf_src_q      <= WSEL_NONE;
            pending_q     <= '0;
            wb_conflict_q <= 1'b0;
            starve_cnt_q  <= '0;
        end else begin
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            rf_src_q      <= rf_src_d;
            pending_q     <= pending_d;
            wb_conflict_q <= wb_conflict_d;
            starve_cnt_q  <= starve_cnt_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign rf_src      = rf_src_q;
    assign pending     = pending_q;
    assign wb_conflict = wb_conflict_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_regfile_wb_arbiter;
    localparam int N     = 32;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        issue_valid, issue_is_load, issue_stall;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        alu_we, jal_we, ext_valid, ext_ready;
    logic [4:0]  alu_rd, jal_rd, ext_rd;
    logic [31:0] alu_data, pc_plus_four, external_input;
    logic        rf_we, wb_conflict;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pending;
    logic [2:0]  rf_src;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.n(N), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .n_reset(n_reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_is_load(issue_is_load), .issue_stall(issue_stall),
        .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
        .jal_we(jal_we), .jal_rd(jal_rd), .pc_plus_four(pc_plus_four),
        .ext_valid(ext_valid), .ext_rd(ext_rd), .external_input(external_input),
        .ext_ready(ext_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src),
        .pending(pending), .wb_conflict(wb_conflict)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_is_load = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        alu_we = 0; alu_rd = 0; alu_data = 0;
        jal_we = 0; jal_rd = 0; pc_plus_four = 0;
        ext_valid = 0; ext_rd = 0; external_input = 0;
    endtask

    task automatic reset_pulse();
        idle();
        n_reset = 0;
        #3;
        n_reset = 1;
        tick();
    endtask

    // ---------------- reference model: response queue + scoreboard bits ----------------
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } req_t;
    req_t        ext_q[$];
    bit   [31:0] m_pend;
    bit          m_conf, m_we;
    int          m_wait;
    logic [2:0]  m_src;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic bit m_ready();
        return ext_q.size() < DEPTH;
    endfunction

    function automatic bit m_stall();
        return (issue_valid && (m_pend[issue_rs1] || m_pend[issue_rs2] || m_pend[issue_rd]))
               || (m_wait == SMAX);
    endfunction

    task automatic model_reset();
        ext_q.delete();
        m_pend = 0; m_conf = 0; m_we = 0; m_wait = 0; m_src = 0; m_waddr = 0; m_wdata = 0;
    endtask

    task automatic model_step();
        logic [2:0]  src;
        logic [4:0]  rd;
        logic [31:0] d;
        bit          ready, popped, stall;
        int          had;
        req_t        r;
        ready = m_ready(); stall = m_stall();
        had = ext_q.size(); popped = 0; src = 0; rd = 0; d = 0;
        if (jal_we) begin
            src = 3'b010; rd = jal_rd; d = pc_plus_four;
        end else if (alu_we) begin
            src = 3'b001; rd = alu_rd; d = alu_data;
        end else if (had > 0) begin
            r = ext_q.pop_front(); src = 3'b100; rd = r.rd; d = r.data; popped = 1;
        end else if (ext_valid) begin
            src = 3'b100; rd = ext_rd; d = external_input;
        end
        if (ext_valid && ready && !(src == 3'b100 && had == 0)) begin
            r.rd = ext_rd; r.data = external_input;
            ext_q.push_back(r);
        end
        m_we  = (src != 0) && (rd != 0);
        m_src = m_we ? src : 3'b000;
        if (m_we) begin m_waddr = rd; m_wdata = d; end
        if (src == 3'b100) m_pend[rd] = 0;
        if (issue_valid && issue_is_load && !stall && issue_rd != 0) m_pend[issue_rd] = 1;
        m_wait = (had == 0 || popped) ? 0 : ((m_wait < SMAX) ? m_wait + 1 : SMAX);
        m_conf = m_conf | (alu_we & jal_we);
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        logic alu_we; logic [4:0] alu_rd; logic [31:0] alu_data;
        logic jal_we; logic [4:0] jal_rd; logic [31:0] pc4;
        logic ext_v;  logic [4:0] ext_rd; logic [31:0] ext_d;
        logic e_we;   logic [2:0] e_src;  logic [4:0] e_addr; logic [31:0] e_data; logic e_conf;
    } vec_t;
    localparam int NV = 9;
    vec_t vecs[NV];

    req_t got[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 7, 15,           0, 0, 0,   0, 0, 0,  1, 3'b001, 7, 15,           0};
        vecs[1] = '{0, 0, 0,            1, 9, 100, 0, 0, 0,  1, 3'b010, 9, 100,          0};
        vecs[2] = '{0, 0, 0,            0, 0, 0,   1, 3, 12, 1, 3'b100, 3, 12,           0};
        vecs[3] = '{1, 0, 55,           0, 0, 0,   0, 0, 0,  0, 3'b000, 0, 0,            0};
        vecs[4] = '{0, 0, 0,            1, 0, 66,  0, 0, 0,  0, 3'b000, 0, 0,            0};
        vecs[5] = '{0, 0, 0,            0, 0, 0,   1, 0, 77, 0, 3'b000, 0, 0,            0};
        vecs[6] = '{1, 4, 32'hdeadbeef, 0, 0, 0,   1, 6, 5,  1, 3'b001, 4, 32'hdeadbeef, 0};
        vecs[7] = '{0, 0, 0,            0, 0, 0,   0, 0, 0,  1, 3'b100, 6, 5,            0};
        vecs[8] = '{1, 7, 99,           1, 7, 23,  0, 0, 0,  1, 3'b010, 7, 23,           1};

        idle();
        n_reset = 0;
        #2;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_src", rf_src, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_pending", pending, 0);
        chk("rst_conflict", wb_conflict, 0);
        chk("rst_ext_ready", ext_ready, 0);
        #10 n_reset = 1;
        tick();

        for (int i = 0; i < NV; i++) begin
            alu_we = vecs[i].alu_we; alu_rd = vecs[i].alu_rd; alu_data = vecs[i].alu_data;
            jal_we = vecs[i].jal_we; jal_rd = vecs[i].jal_rd; pc_plus_four = vecs[i].pc4;
            ext_valid = vecs[i].ext_v; ext_rd = vecs[i].ext_rd; external_input = vecs[i].ext_d;
            tick();
            chk($sformatf("vec%0d_we", i), rf_we, vecs[i].e_we);
            chk($sformatf("vec%0d_src", i), rf_src, vecs[i].e_src);
            chk($sformatf("vec%0d_conflict", i), wb_conflict, vecs[i].e_conf);
            if (vecs[i].e_we) begin
                chk($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].e_addr);
                chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].e_data);
            end
        end

        // Load-use hazard held until the load data is written back.
        reset_pulse();
        issue_valid = 1; issue_is_load = 1; issue_rd = 5;
        #1 chk("raw_load_issue_stall", issue_stall, 0);
        tick();
        chk("raw_pending_set", pending, 32'h20);
        issue_is_load = 0; issue_rd = 6; issue_rs1 = 5;
        #1 chk("raw_stall_on", issue_stall, 1);
        tick();
        chk("raw_stall_held", issue_stall, 1);
        ext_valid = 1; ext_rd = 5; external_input = 12;
        #1 chk("raw_stall_before_wb", issue_stall, 1);
        tick();
        chk("raw_wb_we", rf_we, 1);
        chk("raw_wb_src", rf_src, 3'b100);
        chk("raw_wb_addr", rf_waddr, 5);
        chk("raw_wb_data", rf_wdata, 12);
        chk("raw_pending_clr", pending, 0);
        chk("raw_stall_off", issue_stall, 0);

        // FIFO head starved by continuous ALU writebacks.
        reset_pulse();
        alu_we = 1; alu_rd = 1; alu_data = 1;
        ext_valid = 1; ext_rd = 3; external_input = 12;
        #1 chk("starve_ext_ready", ext_ready, 1);
        tick();
        ext_valid = 0;
        repeat (3) tick();
        chk("starve_not_yet", issue_stall, 0);
        tick();
        chk("starve_stall_on", issue_stall, 1);
        chk("starve_alu_wins", rf_src, 3'b001);
        tick();
        chk("starve_stall_held", issue_stall, 1);
        alu_we = 0;
        tick();
        chk("starve_drain_src", rf_src, 3'b100);
        chk("starve_drain_addr", rf_waddr, 3);
        chk("starve_drain_data", rf_wdata, 12);
        chk("starve_stall_off", issue_stall, 0);

        // Three responses into a depth-2 FIFO while the port is busy.
        reset_pulse();
        alu_we = 1; alu_rd = 2; alu_data = 7;
        ext_valid = 1; ext_rd = 10; external_input = 100;
        #1 chk("fill_ready0", ext_ready, 1);
        tick();
        ext_rd = 11; external_input = 101;
        #1 chk("fill_ready1", ext_ready, 1);
        tick();
        ext_rd = 12; external_input = 102;
        #1 chk("fill_full_ready", ext_ready, 0);
        tick();
        alu_we = 0;
        got.delete();
        for (int c = 0; c < 10; c++) begin
            bit acc;
            req_t r;
            acc = ext_valid && ext_ready;
            tick();
            if (rf_we && rf_src == 3'b100) begin
                r.rd = rf_waddr; r.data = rf_wdata;
                got.push_back(r);
            end
            if (acc) ext_valid = 0;
        end
        chk("fill_count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            req_t e, a;
            e.rd = 5'(10 + i); e.data = 32'(100 + i);
            a = (i < got.size()) ? got[i] : '0;
            chk($sformatf("fill_order%0d", i), a, e);
        end

        // Reset with a full FIFO, a pending load and a sticky conflict.
        reset_pulse();
        jal_we = 1; jal_rd = 9; pc_plus_four = 50;
        alu_we = 1; alu_rd = 1; alu_data = 33;
        ext_valid = 1; ext_rd = 20; external_input = 200;
        issue_valid = 1; issue_is_load = 1; issue_rd = 8;
        tick();
        jal_we = 0; issue_valid = 0; issue_is_load = 0;
        ext_rd = 21; external_input = 201;
        tick();
        ext_valid = 0;
        #1;
        chk("pre_rst_full", ext_ready, 0);
        chk("pre_rst_pending", pending, 32'h100);
        chk("pre_rst_conflict", wb_conflict, 1);
        n_reset = 0;
        #1;
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_src", rf_src, 0);
        chk("mid_rst_waddr", rf_waddr, 0);
        chk("mid_rst_wdata", rf_wdata, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_conflict", wb_conflict, 0);
        chk("mid_rst_ready", ext_ready, 0);
        idle();
        #2 n_reset = 1;
        tick();
        chk("post_rst_ready", ext_ready, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("post_rst_nowrite%0d", c), rf_we, 0);
        end

        // Random traffic against the model.
        reset_pulse();
        model_reset();
        begin
            int busy_left;
            busy_left = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                chk("rnd_we", rf_we, m_we);
                chk("rnd_src", rf_src, m_src);
                if (m_we) begin
                    chk("rnd_waddr", rf_waddr, m_waddr);
                    chk("rnd_wdata", rf_wdata, m_wdata);
                end
                chk("rnd_pending", pending, m_pend);
                chk("rnd_conflict", wb_conflict, m_conf);

                if (busy_left == 0 && $urandom_range(0, 15) == 0) busy_left = $urandom_range(3, 8);
                alu_we = (busy_left > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
                if (busy_left > 0) busy_left--;
                alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
                jal_we = ($urandom_range(0, 7) == 0);
                jal_rd = 5'($urandom_range(0, 7)); pc_plus_four = $urandom;
                ext_valid = ($urandom_range(0, 4) < 2);
                ext_rd = 5'($urandom_range(0, 7)); external_input = $urandom;
                issue_valid = ($urandom_range(0, 1) == 1);
                issue_is_load = ($urandom_range(0, 2) == 0);
                issue_rs1 = 5'($urandom_range(0, 7));
                issue_rs2 = 5'($urandom_range(0, 7));
                issue_rd  = 5'($urandom_range(0, 7));
                #1;
                chk("rnd_ext_ready", ext_ready, m_ready());
                chk("rnd_issue_stall", issue_stall, m_stall());
                model_step();
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
